// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Default number of REQ cycles allowed before a transaction is aborted.
    localparam int unsigned DMEM_TIMEOUT = 16;

    // Width of a counter that must be able to hold the value t.
    function automatic int unsigned cnt_width(input int unsigned t);
        return $clog2(t + 1);
    endfunction

    // Byte enables for an access: all lanes for words, one lane for bytes.
    function automatic logic [3:0] lane_be(input logic is_byte, input logic [1:0] lane);
        if (!is_byte) begin
            return 4'b1111;
        end
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: store enables/data replication and load byte extraction.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        st_byte,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic        ld_byte,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_data,
    output logic [31:0] ld_result
);

    // Store side: enables from the lane, byte data replicated across all lanes.
    always_comb begin
        st_be    = lane_be(st_byte, st_lane);
        st_wdata = st_byte ? {4{st_data[7:0]}} : st_data;
    end

    // Load side: select the addressed byte and zero-extend, or pass the word.
    always_comb begin
        ld_result = '0;
        if (ld_byte) begin
            case (ld_lane)
                2'd0:    ld_result[7:0] = ld_data[7:0];
                2'd1:    ld_result[7:0] = ld_data[15:8];
                2'd2:    ld_result[7:0] = ld_data[23:16];
                default: ld_result[7:0] = ld_data[31:24];
            endcase
        end else begin
            ld_result = ld_data;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns the datapath's single-cycle memory
// strobes into a req/ack bus transaction, stalling the core until it retires.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        ByteAccess,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignFault,
    output logic        BusAbort,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    dmem_state_t   state;
    dmem_state_t   state_n;
    logic [CW-1:0] cnt;
    logic          access;
    logic          aligned;
    logic          timeout;
    logic          byte_q;
    logic [1:0]    lane_q;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_result;

    assign access  = MemWrite | MemRead;
    assign aligned = ByteAccess | (ALUResult[1:0] == 2'b00);
    assign timeout = (cnt == CW'(TIMEOUT - 1));

    dmem_lane u_lane (
        .st_byte   (ByteAccess),
        .st_lane   (ALUResult[1:0]),
        .st_data   (WriteData),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_byte   (byte_q),
        .ld_lane   (lane_q),
        .ld_data   (bus_rdata),
        .ld_result (ld_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: DONE always returns to IDLE so held strobes cannot retrigger.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (access) state_n = aligned ? REQ : DONE;
            REQ:     if (bus_ack || timeout) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Stall: raised combinationally on a new access and held through REQ.
    always_comb begin
        Stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    Stall = access;
                REQ:     Stall = 1'b1;
                default: Stall = 1'b0;
            endcase
        end
    end

    // Bus launch/hold, wait-state counter, load capture and fault pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_be        <= '0;
            byte_q        <= 1'b0;
            lane_q        <= '0;
            ReadData      <= '0;
            MisalignFault <= 1'b0;
            BusAbort      <= 1'b0;
        end else begin
            MisalignFault <= 1'b0;
            BusAbort      <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access) begin
                        if (aligned) begin
                            bus_req   <= 1'b1;
                            bus_we    <= MemWrite;
                            bus_addr  <= {ALUResult[31:2], 2'b00};
                            bus_be    <= st_be;
                            bus_wdata <= st_wdata;
                            byte_q    <= ByteAccess;
                            lane_q    <= ALUResult[1:0];
                        end else begin
                            MisalignFault <= 1'b1;
                            ReadData      <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        if (!bus_we) begin
                            ReadData <= ld_result;
                        end
                    end else if (timeout) begin
                        bus_req  <= 1'b0;
                        cnt      <= '0;
                        ReadData <= '0;
                        BusAbort <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and randomized checks of dmem_ctrl against a transaction-level model.
module tb_dmem_ctrl;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead, ByteAccess;
    logic [31:0] ALUResult, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MisalignFault, BusAbort;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int unsigned ncmp  = 0;
    int unsigned nfail = 0;
    logic [31:0] model_rd = '0;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .ByteAccess    (ByteAccess),
        .ALUResult     (ALUResult),
        .WriteData     (WriteData),
        .ReadData      (ReadData),
        .Stall         (Stall),
        .MisalignFault (MisalignFault),
        .BusAbort      (BusAbort),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_be        (bus_be),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete memory instruction, started in IDLE at posedge+1.
    task automatic do_access(input bit wr, input bit rd, input bit bt,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdat, input int unsigned waits,
                             input bit noack);
        bit          misal, is_wr, first;
        int unsigned stalls, reqs, cyc, exp_stall, exp_req, lane;
        logic [31:0] exp_be, exp_wd, exp_rd;
        is_wr  = wr;
        lane   = addr % 4;
        misal  = !bt && (lane != 0);
        exp_be = bt ? (32'd1 << lane) : 32'd15;
        exp_wd = bt ? (wd & 32'hFF) * 32'h01010101 : wd;
        if (misal) begin
            exp_stall = 1; exp_req = 0; exp_rd = '0;
        end else if (noack) begin
            exp_stall = 1 + TO; exp_req = TO; exp_rd = '0;
        end else begin
            exp_stall = 2 + waits; exp_req = waits + 1;
            if (is_wr)   exp_rd = model_rd;
            else if (bt) exp_rd = (rdat >> (8 * lane)) & 32'hFF;
            else         exp_rd = rdat;
        end

        MemWrite = wr; MemRead = rd; ByteAccess = bt;
        ALUResult = addr; WriteData = wd;
        #1;
        stalls = 0; reqs = 0; cyc = 0; first = 1'b1;
        while (Stall === 1'b1 && cyc < 64) begin
            stalls++;
            if (bus_req === 1'b1) begin
                reqs++;
                if (first) begin
                    first = 1'b0;
                    chk("bus_addr", bus_addr, addr & ~32'd3);
                    chk("bus_be",   {28'd0, bus_be}, exp_be);
                    chk("bus_we",   {31'd0, bus_we}, {31'd0, is_wr});
                    if (is_wr) chk("bus_wdata", bus_wdata, exp_wd);
                end
                if (!noack && (reqs - 1 == waits)) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdat;
                end else begin
                    bus_rdata = $urandom;
                end
            end
            tick;
            bus_ack = 1'b0;
            cyc++;
        end
        chk("stall_cycles", stalls, exp_stall);
        chk("req_cycles",   reqs,   exp_req);
        chk("done_stall",   {31'd0, Stall},         32'd0);
        chk("done_req",     {31'd0, bus_req},       32'd0);
        chk("done_rdata",   ReadData,               exp_rd);
        chk("misalign",     {31'd0, MisalignFault}, {31'd0, misal});
        chk("abort",        {31'd0, BusAbort},      {31'd0, (noack && !misal)});
        model_rd = exp_rd;

        // Next instruction has no memory op; a stray ack must not disturb anything.
        MemWrite = 1'b0; MemRead = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h5A5A5A5A;
        tick;
        bus_ack = 1'b0;
        chk("idle_stall", {31'd0, Stall},         32'd0);
        chk("idle_req",   {31'd0, bus_req},       32'd0);
        chk("idle_pulse", {30'd0, MisalignFault, BusAbort}, 32'd0);
        chk("idle_rdata", ReadData, model_rd);
    endtask

    initial begin
        reset = 1'b1;
        MemWrite = 1'b0; MemRead = 1'b1; ByteAccess = 1'b0;
        ALUResult = '0; WriteData = '0; bus_rdata = '0; bus_ack = 1'b0;
        tick; tick;
        chk("rst_stall", {31'd0, Stall},   32'd0);
        chk("rst_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_rdata", ReadData,         32'd0);
        chk("rst_bus",   {bus_we, bus_be, MisalignFault, BusAbort}, 32'd0);
        chk("rst_addr",  bus_addr,  32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        MemRead = 1'b0;
        reset = 1'b0;
        tick;

        // Directed cases
        do_access(0, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        do_access(1, 0, 1, 32'h203, 32'h12345678, 32'h0, 0, 0);
        do_access(0, 1, 1, 32'h302, 32'h0, 32'hAABBCCDD, 3, 0);
        do_access(1, 0, 0, 32'h208, 32'hCAFEF00D, 32'h0, 1, 0);
        do_access(0, 1, 0, 32'h102, 32'h0, 32'h11111111, 0, 0);
        do_access(0, 1, 1, 32'h301, 32'h0, 32'h44332211, 0, 0);
        do_access(0, 1, 0, 32'h400, 32'h0, 32'h0, 0, 1);
        do_access(1, 1, 0, 32'h40C, 32'h87654321, 32'h0, 2, 0);

        // Reset during the second REQ cycle abandons the transaction
        MemRead = 1'b1; ByteAccess = 1'b0; ALUResult = 32'h500;
        tick; tick;
        chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
        reset = 1'b1;
        tick;
        chk("mid_rst_req",   {31'd0, bus_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, Stall},   32'd0);
        MemRead = 1'b0; reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        tick;
        bus_ack = 1'b0;
        chk("post_rst_req",   {31'd0, bus_req}, 32'd0);
        chk("post_rst_stall", {31'd0, Stall},   32'd0);
        chk("post_rst_rdata", ReadData,         32'd0);
        model_rd = '0;
        do_access(0, 1, 0, 32'h504, 32'h0, 32'h0BADCAFE, 1, 0);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            bit          r_wr, r_rd, r_bt, r_na;
            int unsigned kind;
            kind = $urandom_range(0, 2);
            r_wr = (kind != 1);
            r_rd = (kind != 0);
            r_bt = $urandom_range(0, 1);
            r_na = ($urandom_range(0, 9) == 0);
            do_access(r_wr, r_rd, r_bt, $urandom, $urandom, $urandom,
                      $urandom_range(0, 4), r_na);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller downstream of the single-cycle datapath: consumes ALUResult (address), WriteData and the controller's memory strobes, produces ReadData for the result mux.
- Converts the single-cycle memory assumption into a req/ack bus transaction with wait states, byte-lane handling, misalignment fault and bus timeout.
- Drives Stall to hold the PC register (enable = ~Stall) and suppress RegWrite until the access completes.

Parameters:
- TIMEOUT, 16, max REQ-state cycles waiting for bus_ack before abort (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- MemWrite  in  1  store request from controller
- MemRead  in  1  load request from controller (MemtoReg-qualified)
- ByteAccess  in  1  1 = LDRB/STRB, 0 = word
- ALUResult  in  32  byte address
- WriteData  in  32  store data (low byte used when ByteAccess)
- ReadData  out  32  load result to resmux
- Stall  out  1  hold PC / block register write this cycle
- MisalignFault  out  1  one-cycle pulse: word access with addr[1:0]!=0
- BusAbort  out  1  one-cycle pulse: timeout expired
- bus_req  out  1  bus request, registered
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables
- bus_rdata  in  32  read data, valid when bus_ack
- bus_ack  in  1  transaction complete

Behaviour:
- Reset (synchronous, active-high): state IDLE, counter 0, bus_req/bus_we/bus_be/bus_addr/bus_wdata = 0, ReadData = 0, MisalignFault = BusAbort = 0; Stall forced 0 while reset high.
- access = MemWrite | MemRead; both high is treated as a write (MemWrite priority).
- States: IDLE, REQ, DONE.
- IDLE, access=0: Stall=0, remain.
- IDLE, access=1, aligned (ByteAccess or addr[1:0]==0): Stall=1 (combinational, same cycle). Latch bus_addr, bus_we, bus_be, bus_wdata. Assert bus_req on the next edge and go to REQ.
- IDLE, access=1, misaligned word: Stall=1; no bus transaction; go to DONE with ReadData=0. MisalignFault pulses during the DONE cycle.
- REQ: Stall=1; bus_req and all bus_* outputs held stable; counter increments each cycle.
  - bus_ack=1: capture load data into ReadData (stores leave ReadData unchanged), drop bus_req on the edge, go to DONE.
  - counter==TIMEOUT-1 with no ack: drop bus_req, ReadData=0, go to DONE. BusAbort pulses during the DONE cycle.
  - bus_ack is ignored outside REQ.
- DONE: Stall=0, so the instruction retires, the PC advances and the regfile writes at this edge. Unconditionally return to IDLE (the held access strobes must not retrigger). Counter cleared.
- Minimum access latency: 3 cycles (IDLE, REQ with ack, DONE), i.e. 2 stall cycles. Each extra wait state adds one.
- Byte lanes, lane = addr[1:0]:
  - byte store: bus_be = 1<<lane, bus_wdata = {4{WriteData[7:0]}}
  - word store: bus_be = 4'b1111
  - byte load: ReadData = {24'b0, bus_rdata[8*lane+:8]} (zero-extend)
  - word load: ReadData = bus_rdata
- bus_be = 4'b1111 for word loads, 1<<lane for byte loads.
- Reset during REQ: bus_req low after the reset edge, the transaction is abandoned, and a late bus_ack is ignored.

Decomposition:
- Package dmem_pkg: state enum (IDLE, REQ, DONE), TIMEOUT default, counter width $clog2(TIMEOUT+1).
- Sub-module dmem_lane (combinational): store be/wdata generation and load byte extraction/zero-extension. The FSM and registers live in dmem_ctrl.

Test Plan:
- Word load, addr 0x100, ack in first REQ cycle, bus_rdata 0xDEADBEEF -> Stall high for 2 cycles; ReadData=0xDEADBEEF in DONE; bus_be=4'hF, bus_addr=0x100.
- Byte store, addr 0x203, WriteData 0x12345678 -> bus_be=4'b1000, bus_wdata=0x78787878, bus_addr=0x200, bus_we=1.
- Byte load, addr 0x302, bus_rdata 0xAABBCCDD, ack after 3 wait cycles -> Stall high 5 cycles; ReadData=0x000000BB.
- Word load, addr 0x102 -> no bus_req; MisalignFault pulses 1 cycle; ReadData=0; Stall high 1 cycle.
- No ack, TIMEOUT=16 -> bus_req high exactly 16 cycles; BusAbort pulses; ReadData=0; late ack ignored.
- Reset asserted in 2nd REQ cycle -> bus_req=0, state IDLE after the edge; next access starts cleanly.
